// File: rtl/seq_mult_hs_if.sv
// Operand/product handshake bundle for the sequential multiplier.
interface seq_mult_hs_if #(
  parameter int unsigned A_WIDTH = 22,
  parameter int unsigned B_WIDTH = 22
);
  logic                       in_valid;
  logic                       in_ready;
  logic [A_WIDTH-1:0]         a;
  logic [B_WIDTH-1:0]         b;
  logic                       out_valid;
  logic                       out_ready;
  logic [A_WIDTH+B_WIDTH-1:0] product;

  // Producer of operands / consumer of products.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_mult_hs.sv
// Multi-cycle shift-add multiplier, one multiplier bit per cycle, with
// valid/ready handshakes on operand and product sides. One op in flight.
module seq_mult_hs #(
  parameter int unsigned A_WIDTH = 22,
  parameter int unsigned B_WIDTH = 22,
  parameter int unsigned TC_MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  seq_mult_hs_if.slave bus
);

  localparam int unsigned P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int unsigned CNT_WIDTH = $clog2(B_WIDTH + 1);
  localparam bit          TC        = (TC_MODE != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [P_WIDTH-1:0]   product_q, product_d;
  logic [P_WIDTH-1:0]   acc_q, acc_d;
  logic [P_WIDTH-1:0]   mcand_q, mcand_d;
  logic [B_WIDTH-1:0]   mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic                 accept_c;
  logic                 a_neg_c, b_neg_c;
  logic [A_WIDTH-1:0]   a_mag_c;
  logic [B_WIDTH-1:0]   b_mag_c;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

  // Operand acceptance and magnitude/sign extraction; -2^(W-1) maps to 2^(W-1) unsigned.
  always_comb begin
    accept_c = bus.in_valid && in_ready_q && (state_q == IDLE);
    a_neg_c  = TC && bus.a[A_WIDTH-1];
    b_neg_c  = TC && bus.b[B_WIDTH-1];
    a_mag_c  = a_neg_c ? A_WIDTH'(-bus.a) : bus.a;
    b_mag_c  = b_neg_c ? B_WIDTH'(-bus.b) : bus.b;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      count_q     <= count_d;
    end
  end

  // Next-state: fixed B_WIDTH iterations plus one finalize edge, then wait for consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = BUSY;
      BUSY: if (count_q == CNT_WIDTH'(B_WIDTH)) state_d = DONE;
      DONE: if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values; in_ready only rises when IDLE is actually entered.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = out_valid_q;
    product_d   = product_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          acc_d    = '0;
          mcand_d  = P_WIDTH'(a_mag_c);
          mplier_d = b_mag_c;
          neg_d    = a_neg_c ^ b_neg_c;
          count_d  = '0;
        end
      end
      BUSY: begin
        if (count_q != CNT_WIDTH'(B_WIDTH)) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CNT_WIDTH'(1);
        end else begin
          product_d   = neg_q ? P_WIDTH'(-acc_q) : acc_q;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Bench: signed and unsigned instances driven in lockstep, checked against
// plain-arithmetic reference products, fixed vectors, and handshake corners.
module tb_seq_mult_hs;

  localparam int unsigned AW  = 22;
  localparam int unsigned BW  = 22;
  localparam int unsigned PW  = AW + BW;
  localparam int          LAT = BW + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic          out_ready;

  int checks;
  int errors;

  seq_mult_hs_if #(.A_WIDTH(AW), .B_WIDTH(BW)) if_s ();
  seq_mult_hs_if #(.A_WIDTH(AW), .B_WIDTH(BW)) if_u ();

  assign if_s.in_valid  = in_valid;
  assign if_s.a         = a;
  assign if_s.b         = b;
  assign if_s.out_ready = out_ready;
  assign if_u.in_valid  = in_valid;
  assign if_u.a         = a;
  assign if_u.b         = b;
  assign if_u.out_ready = out_ready;

  seq_mult_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .TC_MODE(1)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s.slave)
  );

  seq_mult_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .TC_MODE(0)) u_dut_u (
    .clk (clk),
    .rst (rst),
    .bus (if_u.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [PW-1:0] exp_s;
    logic [PW-1:0] exp_u;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [PW-1:0] ref_s(input logic [AW-1:0] x, input logic [BW-1:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    return PW'(sx * sy);
  endfunction

  function automatic logic [PW-1:0] ref_u(input logic [AW-1:0] x, input logic [BW-1:0] y);
    longint ux = longint'(x);
    longint uy = longint'(y);
    return PW'(ux * uy);
  endfunction

  function automatic logic [AW-1:0] pick_operand();
    logic [AW-1:0] corners[5];
    corners[0] = '0;
    corners[1] = AW'(1);
    corners[2] = '1;
    corners[3] = AW'(22'h200000);
    corners[4] = AW'(22'h1FFFFF);
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return AW'($urandom);
  endfunction

  task automatic check(input string tag, input string what,
                       input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h, expected %h", tag, what, got, exp);
    end
  endtask

  // One full operation: accept, latency, product, optional backpressure, release.
  task automatic run_op(input string tag, input logic [AW-1:0] xa, input logic [BW-1:0] xb,
                        input logic [PW-1:0] es, input logic [PW-1:0] eu, input int hold);
    int waitc;
    int lat;
    longint ps, sa, sb;
    waitc = 0;
    while (!(if_s.in_ready && if_u.in_ready) && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 100) begin
      check(tag, "in_ready_timeout", 64'(if_s.in_ready), 64'd1);
      return;
    end
    in_valid  = 1'b1;
    a         = xa;
    b         = xb;
    out_ready = 1'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!if_s.out_valid && lat < 100) begin
      a         = AW'($urandom);
      b         = BW'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check(tag, "latency", 64'(lat), 64'(LAT));
    check(tag, "out_valid_u", 64'(if_u.out_valid), 64'd1);
    check(tag, "product_s", 64'(if_s.product), 64'(es));
    check(tag, "product_u", 64'(if_u.product), 64'(eu));
    if (xb != '0) begin
      ps = longint'($signed(if_s.product));
      sa = longint'($signed(xa));
      sb = longint'($signed(xb));
      check(tag, "div_s", 64'(ps / sb), 64'(sa));
      check(tag, "rem_s", 64'(ps % sb), 64'd0);
      check(tag, "div_u", 64'(longint'(if_u.product) / longint'(xb)), 64'(longint'(xa)));
    end
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      a         = AW'($urandom);
      b         = BW'($urandom);
      @(negedge clk);
      check(tag, "hold_product_s", 64'(if_s.product), 64'(es));
      check(tag, "hold_valid", 64'({if_s.out_valid, if_u.out_valid}), 64'd3);
      check(tag, "hold_in_ready", 64'({if_s.in_ready, if_u.in_ready}), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check(tag, "released_valid", 64'({if_s.out_valid, if_u.out_valid}), 64'd0);
    check(tag, "released_in_ready", 64'({if_s.in_ready, if_u.in_ready}), 64'd3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_valid;
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    vecs[0] = '{22'd7,       22'd3,       44'd21,            44'd21};
    vecs[1] = '{22'h3FFC18,  22'd19,      44'hFFFFFFFB5C8,   44'h000004BFB5C8};
    vecs[2] = '{22'h200000,  22'h200000,  44'h40000000000,   44'h40000000000};
    vecs[3] = '{22'h200000,  22'h1FFFFF,  44'hC0000200000,   44'h3FFFFE00000};
    vecs[4] = '{22'd5,       22'h3FFFFC,  44'hFFFFFFFFFEC,   44'h0000013FFFEC};
    vecs[5] = '{22'd0,       22'h3FFFFF,  44'd0,             44'd0};
    vecs[6] = '{22'h3FFFFF,  22'h3FFFFF,  44'd1,             44'hFFFFF800001};
    vecs[7] = '{22'h3FFFFF,  22'd0,       44'd0,             44'd0};

    // Reset state.
    #1;
    check("reset", "in_ready", 64'({if_s.in_ready, if_u.in_ready}), 64'd0);
    check("reset", "out_valid", 64'({if_s.out_valid, if_u.out_valid}), 64'd0);
    check("reset", "product", 64'(if_s.product | if_u.product), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset", "in_ready_after", 64'({if_s.in_ready, if_u.in_ready}), 64'd3);

    // Fixed vectors.
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_s, vecs[i].exp_u, i % 3);

    // Long backpressure with ignored input traffic, then a fresh op.
    run_op("hold10", 22'd1234, 22'h3FFF00, ref_s(22'd1234, 22'h3FFF00),
           ref_u(22'd1234, 22'h3FFF00), 10);
    run_op("after_hold", 22'd7, 22'd3, 44'd21, 44'd21, 0);

    // Reset in the middle of BUSY drops the op.
    in_valid = 1'b1;
    a        = 22'd123;
    b        = 22'd456;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", "in_ready", 64'({if_s.in_ready, if_u.in_ready}), 64'd0);
    check("rst_busy", "out_valid", 64'({if_s.out_valid, if_u.out_valid}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_s.out_valid || if_u.out_valid) seen_valid++;
    end
    check("rst_busy", "no_out_valid", 64'(seen_valid), 64'd0);
    check("rst_busy", "in_ready_after", 64'({if_s.in_ready, if_u.in_ready}), 64'd3);
    run_op("after_rst", 22'd5, 22'h3FFFFC, 44'hFFFFFFFFFEC, 44'h0000013FFFEC, 0);

    // Randomized operands and backpressure against the arithmetic reference.
    for (int n = 0; n < 1000; n++) begin
      ra = pick_operand();
      rb = BW'(pick_operand());
      run_op($sformatf("rand%0d", n), ra, rb, ref_s(ra, rb), ref_u(ra, rb),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
